// File: rtl/reduce_combine.sv
// reduce_combine: combining stage of a reduction tree.
// It takes {children, flit} words from the reduction instruction decoder.
// Contributions that share a {contextId, tag} key are folded into a small table.
// When all expected contributions are in, one combined flit goes to the parent.
// Leaf operations and non-reduction operations pass straight through, with src rewritten.
// Optional feature: define REDUCE_TIMEOUT_EN to flush stale partial entries after TIMEOUT idle cycles.
//
// Flit layout (73 bits):
//   [72]    valid
//   [71:63] dst
//   [62:54] src
//   [53:46] contextId
//   [45:38] tag
//   [37:36] reserved
//   [35:32] op
//   [31:0]  payload
module reduce_combine #(
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenWidth = 3,
  parameter int         TableSize     = 4,
  parameter int         TIMEOUT       = 15,
  parameter logic [2:0] rank_x        = 3'b000,
  parameter logic [2:0] rank_y        = 3'b000,
  parameter logic [2:0] rank_z        = 3'b000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth+ChildrenWidth-1:0] packetIn,
  output logic                               in_ready,
  output logic [FlitWidth-1:0]               packetOut,
  input  logic                               out_ready,
  output logic                               table_full
);

  localparam int IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;
  localparam logic [3:0] OpPartial = 4'b1110;
  localparam logic [ChildrenWidth-1:0] RemOne = ChildrenWidth'(1);

  // Reduction ops are 0000..0101; every other op code is forwarded untouched.
  function automatic logic is_reduce_op(input logic [3:0] op);
    is_reduce_op = (op <= 4'b0101);
  endfunction

  // Fold one payload into an accumulator.
  function automatic logic [31:0] combine(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: combine = a + b;
      4'b0001: combine = ($signed(a) > $signed(b)) ? a : b;
      4'b0010: combine = ($signed(a) < $signed(b)) ? a : b;
      4'b0011: combine = a & b;
      4'b0100: combine = a | b;
      4'b0101: combine = a ^ b;
      default: combine = a;
    endcase
  endfunction

  // Reduction table state
  logic [TableSize-1:0]     valid_q, valid_d;
  logic [15:0]              key_q [TableSize];
  logic [15:0]              key_d [TableSize];
  logic [3:0]               op_q  [TableSize];
  logic [3:0]               op_d  [TableSize];
  logic [8:0]               dst_q [TableSize];
  logic [8:0]               dst_d [TableSize];
  logic [31:0]              acc_q [TableSize];
  logic [31:0]              acc_d [TableSize];
  logic [ChildrenWidth-1:0] rem_q [TableSize];
  logic [ChildrenWidth-1:0] rem_d [TableSize];
  logic [FlitWidth-1:0]     out_q, out_d;
  logic                     table_full_q;

  // Input field decode
  logic                     in_valid_s;
  logic [ChildrenWidth-1:0] children_s;
  logic [3:0]               op_s;
  logic [15:0]              key_s;
  logic [31:0]              payload_s;
  logic [8:0]               dst_s;
  logic [8:0]               rank_s;

  assign in_valid_s = packetIn[72];
  assign children_s = packetIn[FlitWidth+ChildrenWidth-1:FlitWidth];
  assign op_s       = packetIn[35:32];
  assign key_s      = packetIn[53:38];
  assign payload_s  = packetIn[31:0];
  assign dst_s      = packetIn[71:63];
  assign rank_s     = {rank_x, rank_y, rank_z};

  logic            hit_s, free_s;
  logic [IdxW-1:0] hit_idx_s, free_idx_s;

  // Key lookup and lowest free slot; descending scan so the lowest index wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {IdxW{1'b0}};
    free_s     = 1'b0;
    free_idx_s = {IdxW{1'b0}};
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == key_s)) begin
        hit_s     = 1'b1;
        hit_idx_s = IdxW'(i);
      end else if (!valid_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = IdxW'(i);
      end else begin
        // slot holds a different key: nothing to record
      end
    end
  end

  logic        passthru_s, out_slot_ok_s, accept_s;
  logic        do_pass_s, do_hit_s, do_alloc_s, hit_done_s;
  logic [31:0] combined_s;

  // Accept / route decision for the incoming flit.
  always_comb begin
    passthru_s    = !is_reduce_op(op_s) || (children_s == {ChildrenWidth{1'b0}}) ||
                    (hit_s && (op_q[hit_idx_s] != op_s));
    out_slot_ok_s = !out_q[72] || out_ready;
    in_ready      = out_slot_ok_s && (hit_s || passthru_s || free_s);
    accept_s      = in_valid_s && in_ready;
    do_pass_s     = accept_s && passthru_s;
    do_hit_s      = accept_s && !passthru_s && hit_s;
    do_alloc_s    = accept_s && !passthru_s && !hit_s;
    hit_done_s    = do_hit_s && (rem_q[hit_idx_s] == RemOne);
    combined_s    = combine(op_q[hit_idx_s], acc_q[hit_idx_s], payload_s);
  end

`ifdef REDUCE_TIMEOUT_EN
  logic [3:0]      wait_q [TableSize];
  logic [3:0]      wait_d [TableSize];
  logic            flush_any_s, flush_fire_s;
  logic [IdxW-1:0] flush_idx_s;

  // Per-entry idle countdown and lowest-index expired-entry selection.
  always_comb begin
    flush_any_s = 1'b0;
    flush_idx_s = {IdxW{1'b0}};
    for (int i = TableSize - 1; i >= 0; i--) begin
      if ((do_alloc_s && (free_idx_s == IdxW'(i))) || (do_hit_s && (hit_idx_s == IdxW'(i)))) begin
        wait_d[i] = 4'(TIMEOUT);
      end else if (valid_q[i] && (wait_q[i] != 4'd0)) begin
        wait_d[i] = wait_q[i] - 4'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
      if (valid_q[i] && (wait_q[i] == 4'd0) && !(do_hit_s && (hit_idx_s == IdxW'(i)))) begin
        flush_any_s = 1'b1;
        flush_idx_s = IdxW'(i);
      end else begin
        // entry not expired or being refreshed this cycle
      end
    end
    flush_fire_s = flush_any_s && out_slot_ok_s && !(do_pass_s || hit_done_s);
  end

  // Waitcount registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TableSize; i++) wait_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < TableSize; i++) wait_q[i] <= wait_d[i];
    end
  end
`else
  logic [3:0] unused_timeout_s;
  assign unused_timeout_s = 4'(TIMEOUT);
`endif

  // Next-state for table entries: allocate, fold, free.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < TableSize; i++) begin
      key_d[i] = key_q[i];
      op_d[i]  = op_q[i];
      dst_d[i] = dst_q[i];
      acc_d[i] = acc_q[i];
      rem_d[i] = rem_q[i];
    end
    if (do_alloc_s) begin
      valid_d[free_idx_s] = 1'b1;
      key_d[free_idx_s]   = key_s;
      op_d[free_idx_s]    = op_s;
      dst_d[free_idx_s]   = dst_s;
      acc_d[free_idx_s]   = payload_s;
      rem_d[free_idx_s]   = children_s;
    end else if (do_hit_s) begin
      acc_d[hit_idx_s] = combined_s;
      rem_d[hit_idx_s] = rem_q[hit_idx_s] - RemOne;
      if (hit_done_s) begin
        valid_d[hit_idx_s] = 1'b0;
      end else begin
        valid_d[hit_idx_s] = 1'b1;
      end
    end else begin
      // pass-through or idle: table untouched by the input
    end
`ifdef REDUCE_TIMEOUT_EN
    if (flush_fire_s) begin
      valid_d[flush_idx_s] = 1'b0;
    end else begin
      // no partial flush this cycle
    end
`endif
  end

  // Output register next value; input emission outranks a timeout flush.
  always_comb begin
    if (do_pass_s) begin
      out_d = {1'b1, packetIn[71:63], rank_s, packetIn[53:0]};
    end else if (hit_done_s) begin
      out_d = {1'b1, dst_q[hit_idx_s], rank_s, key_q[hit_idx_s], 2'b00,
               op_q[hit_idx_s], combined_s};
`ifdef REDUCE_TIMEOUT_EN
    end else if (flush_fire_s) begin
      out_d = {1'b1, dst_q[flush_idx_s], rank_s, key_q[flush_idx_s], 2'b00,
               OpPartial, acc_q[flush_idx_s]};
`endif
    end else if (out_q[72] && out_ready) begin
      out_d = {FlitWidth{1'b0}};
    end else begin
      out_d = out_q;
    end
  end

  // Table, output and table_full registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= {TableSize{1'b0}};
      out_q        <= {FlitWidth{1'b0}};
      table_full_q <= 1'b0;
      for (int i = 0; i < TableSize; i++) begin
        key_q[i] <= 16'd0;
        op_q[i]  <= 4'd0;
        dst_q[i] <= 9'd0;
        acc_q[i] <= 32'd0;
        rem_q[i] <= {ChildrenWidth{1'b0}};
      end
    end else begin
      valid_q      <= valid_d;
      out_q        <= out_d;
      table_full_q <= &valid_q;
      for (int i = 0; i < TableSize; i++) begin
        key_q[i] <= key_d[i];
        op_q[i]  <= op_d[i];
        dst_q[i] <= dst_d[i];
        acc_q[i] <= acc_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign packetOut  = out_q;
  assign table_full = table_full_q;

endmodule

// File: tb/tb_reduce_combine.sv
// Directed testbench for reduce_combine (rank 0,0,0, TIMEOUT 15).
module tb_reduce_combine;

  logic        clk = 1'b0;
  logic        rst;
  logic [75:0] packetIn;
  logic        in_ready;
  logic [72:0] packetOut;
  logic        out_ready;
  logic        table_full;

  int n_cmp  = 0;
  int n_fail = 0;

  reduce_combine #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .packetIn  (packetIn),
    .in_ready  (in_ready),
    .packetOut (packetOut),
    .out_ready (out_ready),
    .table_full(table_full)
  );

  always #5 clk = ~clk;

  // Input word; src is deliberately nonzero so the rank rewrite is visible.
  function automatic logic [75:0] mk(input logic [2:0] ch, input logic [8:0] dst,
                                     input logic [7:0] ctx, input logic [7:0] tg,
                                     input logic [3:0] op, input logic [31:0] pay);
    mk = {ch, 1'b1, dst, 9'h155, ctx, tg, 2'b00, op, pay};
  endfunction

  // Expected output flit from this node (src = rank = 0).
  function automatic logic [72:0] ef(input logic [8:0] dst, input logic [7:0] ctx,
                                     input logic [7:0] tg, input logic [3:0] op,
                                     input logic [31:0] pay);
    ef = {1'b1, dst, 9'h000, ctx, tg, 2'b00, op, pay};
  endfunction

  task automatic chk(input string name, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [75:0] p);
    @(negedge clk);
    packetIn = p;
    #1;
  endtask

  // Present one flit, require it to be accepted on the next edge.
  task automatic push(input string name, input logic [75:0] p);
    drive(p);
    chk(name, 73'(in_ready), 73'd1);
    tick();
    packetIn = '0;
  endtask

  initial begin
    rst       = 1'b0;
    packetIn  = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out", packetOut, 73'd0);
    chk("rst_full", 73'(table_full), 73'd0);
    chk("rst_ready", 73'(in_ready), 73'd1);
    @(negedge clk);
    rst = 1'b1;

    // Leaf: children 0, max op, forwarded next cycle with src rewritten
    push("leaf_rdy", mk(3'd0, 9'h012, 8'h11, 8'h22, 4'h1, 32'h80000000));
    chk("leaf_out", packetOut, ef(9'h012, 8'h11, 8'h22, 4'h1, 32'h80000000));
    chk("leaf_noalloc", 73'(dut.valid_q), 73'd0);
    tick();
    chk("leaf_drain", packetOut, 73'd0);

    // Sum tree: 5 + 7 + 0xFFFFFFFF = 11 (mod 2^32)
    push("sum_rdy1", mk(3'd2, 9'h021, 8'h00, 8'h03, 4'h0, 32'd5));
    chk("sum_wait1", 73'(packetOut[72]), 73'd0);
    push("sum_rdy2", mk(3'd2, 9'h021, 8'h00, 8'h03, 4'h0, 32'd7));
    chk("sum_wait2", 73'(packetOut[72]), 73'd0);
    push("sum_rdy3", mk(3'd2, 9'h021, 8'h00, 8'h03, 4'h0, 32'hFFFFFFFF));
    chk("sum_out", packetOut, ef(9'h021, 8'h00, 8'h03, 4'h0, 32'd11));

    // Signed min: min(-3, 2) = -3
    push("min_rdy1", mk(3'd1, 9'h022, 8'h01, 8'h01, 4'h2, 32'hFFFFFFFD));
    push("min_rdy2", mk(3'd1, 9'h022, 8'h01, 8'h01, 4'h2, 32'h00000002));
    chk("min_out", packetOut, ef(9'h022, 8'h01, 8'h01, 4'h2, 32'hFFFFFFFD));

    // Op mismatch on hit forwards the flit and leaves the OR entry intact
    push("mis_rdy1", mk(3'd1, 9'h033, 8'h02, 8'h02, 4'h4, 32'h000000F0));
    push("mis_rdy2", mk(3'd1, 9'h033, 8'h02, 8'h02, 4'h5, 32'h0000000F));
    chk("mis_pass", packetOut, ef(9'h033, 8'h02, 8'h02, 4'h5, 32'h0000000F));
    push("mis_rdy3", mk(3'd1, 9'h033, 8'h02, 8'h02, 4'h4, 32'h0000000F));
    chk("mis_comb", packetOut, ef(9'h033, 8'h02, 8'h02, 4'h4, 32'h000000FF));
    chk("mis_empty", 73'(dut.valid_q), 73'd0);

    // Full table: four AND keys, a fifth key stalls until key 0 completes
    push("full_a0", mk(3'd1, 9'h044, 8'h05, 8'h0A, 4'h3, 32'hFFFF0000));
    push("full_a1", mk(3'd1, 9'h044, 8'h05, 8'h0B, 4'h3, 32'hA5A5A5A5));
    push("full_a2", mk(3'd1, 9'h044, 8'h05, 8'h0C, 4'h3, 32'hA5A5A5A5));
    push("full_a3", mk(3'd1, 9'h044, 8'h05, 8'h0D, 4'h3, 32'hA5A5A5A5));
    chk("full_nout", 73'(packetOut[72]), 73'd0);
    drive(mk(3'd1, 9'h044, 8'h05, 8'h0E, 4'h3, 32'h00FF00FF));
    chk("full_stall", 73'(in_ready), 73'd0);
    tick();
    chk("full_flag", 73'(table_full), 73'd1);
    chk("full_hold", 73'(packetOut[72]), 73'd0);
    push("full_hit", mk(3'd1, 9'h044, 8'h05, 8'h0A, 4'h3, 32'h0F0F0F0F));
    chk("full_done", packetOut, ef(9'h044, 8'h05, 8'h0A, 4'h3, 32'h0F0F0000));
    push("full_new", mk(3'd1, 9'h044, 8'h05, 8'h0E, 4'h3, 32'h00FF00FF));
    chk("full_flag_lo", 73'(table_full), 73'd0);
    chk("full_idx0", 73'(dut.key_q[0]), 73'h050E);
    tick();
    chk("full_flag_hi", 73'(table_full), 73'd1);

    // Backpressure: pending output holds, input blocked until out_ready
    out_ready = 1'b0;
    push("bp_a_rdy", mk(3'd3, 9'h055, 8'h09, 8'h40, 4'h7, 32'hDEADBEEF));
    chk("bp_a_out", packetOut, ef(9'h055, 8'h09, 8'h40, 4'h7, 32'hDEADBEEF));
    drive(mk(3'd0, 9'h066, 8'h0A, 8'h41, 4'h5, 32'h0BADF00D));
    chk("bp_block", 73'(in_ready), 73'd0);
    tick();
    chk("bp_hold", packetOut, ef(9'h055, 8'h09, 8'h40, 4'h7, 32'hDEADBEEF));
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release", 73'(in_ready), 73'd1);
    tick();
    packetIn = '0;
    chk("bp_b_out", packetOut, ef(9'h066, 8'h0A, 8'h41, 4'h5, 32'h0BADF00D));

    // Reset mid-operation with a full table and a pending output
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out", packetOut, 73'd0);
    chk("mrst_full", 73'(table_full), 73'd0);
    chk("mrst_valid", 73'(dut.valid_q), 73'd0);
    @(negedge clk);
    rst = 1'b1;
    push("fresh_rdy1", mk(3'd1, 9'h044, 8'h05, 8'h0B, 4'h3, 32'h12345678));
    chk("fresh_wait", 73'(packetOut[72]), 73'd0);
    push("fresh_rdy2", mk(3'd1, 9'h044, 8'h05, 8'h0B, 4'h3, 32'hFFFFFFFF));
    chk("fresh_out", packetOut, ef(9'h044, 8'h05, 8'h0B, 4'h3, 32'h12345678));

`ifdef REDUCE_TIMEOUT_EN
    // Partial entry is flushed with op 1110 after the idle timeout
    begin
      logic seen;
      seen = 1'b0;
      push("to_rdy", mk(3'd1, 9'h077, 8'h07, 8'h07, 4'h1, 32'd9));
      for (int k = 0; k < 40 && !seen; k++) begin
        tick();
        if (packetOut[72]) seen = 1'b1;
      end
      chk("to_seen", 73'(seen), 73'd1);
      chk("to_out", packetOut, ef(9'h077, 8'h07, 8'h07, 4'hE, 32'd9));
      chk("to_freed", 73'(dut.valid_q), 73'd0);
    end
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reduce_combine.md
Name: reduce_combine

Overview:
- Downstream stage of the reduction instruction decoder; consumes its 76-bit children-tagged flits and produces 73-bit network flits.
- Keeps a small reduction table keyed by {contextId, tag} and combines payloads from a node's own contribution and its children.
- Emits one combined flit toward the tree parent once all expected contributions have arrived.
- Leaf operations (children==0) and non-reduction ops pass straight through.

Parameters:
- FlitWidth, 73, output flit width (valid bit 72).
- ChildrenWidth, 3, children field width at input bits 75-73.
- TableSize, 4, number of reduction table entries.
- TIMEOUT, 15, idle cycles before a partial entry is flushed (optional feature only).
- rank_x / rank_y / rank_z, 3'b0 each, this node's coordinates, written to src fields of emitted flits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- packetIn  in  76  {children, flit}; bit 72 = valid.
- in_ready  out  1  input accepted this cycle when packetIn[72] && in_ready.
- packetOut  out  73  combined flit; bit 72 = out valid.
- out_ready  in  1  downstream accepts packetOut when packetOut[72] && out_ready.
- table_full  out  1  all entries allocated.

Behaviour:
- Reset (rst=0, async): all entries invalid, packetOut = 0 (valid 0), table_full = 0; in_ready is combinational (see below).
- Fields: op = bits 35-32, contextId = 53-46, tag = 45-38, payload = 31-0.
- Reduction ops:
  - 0000 signed sum (wraps mod 2^32).
  - 0001 signed max.
  - 0010 signed min.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
- Any other op is pass-through.
- Entry fields: valid, key {contextId, tag}, op, dst, payload accumulator, remaining count (ChildrenWidth bits).
- Expected contributions per operation = children + 1.
- Accepted flit, lowest-index rule for allocation; exactly one of the following:
  - Pass-through or children==0: flit forwarded to output register unchanged except src = rank and children dropped.
  - Key hit: accumulator = f(acc, payload); remaining decremented.
    - If remaining was 1: emit {dst, src=rank, op, key, acc result}, entry freed the same cycle.
  - Key miss with free entry: allocate lowest free index; acc = payload, remaining = children.
  - Op mismatch on hit (stored op != incoming op): incoming flit forwarded as pass-through; entry untouched.
- Output register: loaded on the accepting edge, so latency is 1 cycle from input acceptance to packetOut[72]. Held stable until out_ready.
- out_slot_ok = !packetOut[72] || out_ready.
- in_ready = out_slot_ok && (hit || passthrough || any entry free).
- Miss with table full: in_ready = 0 and the flit waits; hits still proceed.
- Only one flit is accepted per cycle.
- table_full updates one cycle after allocation or free.

Optional Feature:
- Macro: REDUCE_TIMEOUT_EN.
- With macro defined:
  - Each entry has a 4-bit waitcount, loaded with TIMEOUT on allocation and on every hit, decremented each idle cycle.
  - On reaching 0, the entry is flushed as a partial result with op = 4'b1110 and the entry is freed.
  - Flush happens only when out_slot_ok and no input emission occurs that cycle; input emission has priority.
  - If several entries expire together, the lowest index flushes first.
- Without the macro: entries wait indefinitely; no waitcount logic exists.

Test Plan:
- Reset mid-operation: entry allocated, rst pulsed low → packetOut = 0, table_full = 0; the next flit with the same key allocates fresh.
- Sum tree: children=2 with payloads 5, 7, 0xFFFFFFFF, op 0000, ctx 0, tag 3 → one flit with payload 11, src = rank, emitted 1 cycle after the third acceptance.
- Leaf: children=0, op 0001, payload 0x80000000 → forwarded next cycle unchanged; no entry allocated.
- Full table: 4 distinct keys allocated, then a 5th new key → in_ready = 0. A hit on key 0 completes and frees entry 0; the 5th key is accepted and allocated in index 0.
- Backpressure: out_ready = 0 with an output pending → in_ready = 0 and packetOut stays stable. Raising out_ready drains it, and the next input is accepted in the same cycle.
- REDUCE_TIMEOUT_EN, TIMEOUT=3: one contribution of max op, payload 9, children=1, then idle → after 3 idle cycles the flit emits with op 1110 and payload 9, and the entry is freed.
